totp_digit_scan: RTL and testbench

//  Downstream of the TOTP stream/HOTP core. When the core signals ready, this block walks the

---
 rtl/totp_digit_scan_pkg.sv | 17 +
 rtl/totp_digit_scan_ctr.sv | 37 +++
 rtl/totp_digit_scan.sv | 141 ++++++++++++++
 tb/tb_totp_digit_scan.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/totp_digit_scan_pkg.sv
// Shared widths, capture-FSM state encoding and the digit-enable decode helper
// used by the TOTP digit capture/scan block.
package totp_digit_scan_pkg;

   localparam int SEL_W = 3;
   localparam int BCD_W = 4;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_CAPTURE = 1'b1
   } state_e;

   function automatic logic [7:0] digit_onehot(input logic [SEL_W-1:0] idx);
      digit_onehot = 8'd1 << idx;
   endfunction

endpackage

// File: rtl/totp_digit_scan_ctr.sv
// Free-running display prescaler plus digit index rotator; tick_o marks the
// last prescaler count, on which the index advances.
module totp_scan_ctr
   import totp_digit_scan_pkg::*;
#(
   parameter int SCAN_DIV   = 1024,
   parameter int NUM_DIGITS = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [SEL_W-1:0] index_o,
   output logic             tick_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_DIGITS - 1);

   logic [PW-1:0]    pre_q;
   logic [SEL_W-1:0] idx_q;

   assign tick_o  = (pre_q == PRE_LAST);
   assign index_o = idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= '0;
         idx_q <= '0;
      end else if (tick_o) begin
         pre_q <= '0;
         idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         pre_q <= pre_q + 1'b1;
      end
   end

endmodule

// File: rtl/totp_digit_scan.sv
// Captures the HOTP/TOTP code digit by digit over the sel/bcd bus, commits it
// atomically and scans the committed digits onto a single 7-segment decoder.
module totp_digit_scan
   import totp_digit_scan_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int SEL_SETTLE = 1,
   parameter int SCAN_DIV   = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ready,
   input  logic [BCD_W-1:0]      bcd,
   input  logic                  start,
   output logic [SEL_W-1:0]      sel,
   output logic [BCD_W-1:0]      scan_bcd,
   output logic [NUM_DIGITS-1:0] digit_en,
   output logic                  valid,
   output logic                  busy
);

   localparam int CW = ($clog2(SEL_SETTLE + 1) > 0) ? $clog2(SEL_SETTLE + 1) : 1;
   localparam logic [CW-1:0]    SETTLE_LAST = CW'(SEL_SETTLE);
   localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_DIGITS - 1);

   state_e           state_q;
   logic             ready_q;
   logic [SEL_W-1:0] sel_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             valid_q;
   logic [BCD_W-1:0] shadow_q    [NUM_DIGITS];
   logic [BCD_W-1:0] committed_q [NUM_DIGITS];

   logic             valid_dly_q;
   logic             tick_q;
   logic [BCD_W-1:0] scan_bcd_q;
   logic [NUM_DIGITS-1:0] digit_en_q;

   logic             trigger_d;
   logic [SEL_W-1:0] scan_idx;
   logic             scan_tick;
   logic [BCD_W-1:0] shown_bcd_d;

   // Rising edge of ready, or a recapture request while the result is still valid.
   assign trigger_d = ready && (!ready_q || start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         sel_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int j = 0; j < NUM_DIGITS; j++) begin
            shadow_q[j]    <= '0;
            committed_q[j] <= '0;
         end
      end else begin
         ready_q <= ready;
         case (state_q)
            ST_IDLE: begin
               if (!ready) valid_q <= 1'b0;
               if (trigger_d) begin
                  state_q <= ST_CAPTURE;
                  busy_q  <= 1'b1;
                  sel_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            ST_CAPTURE: begin
               if (!ready) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  sel_q   <= '0;
                  cnt_q   <= '0;
               end else if (cnt_q == SETTLE_LAST) begin
                  cnt_q <= '0;
                  for (int j = 0; j < NUM_DIGITS; j++)
                     if (SEL_W'(j) == sel_q) shadow_q[j] <= bcd;
                  if (sel_q == SEL_LAST) begin
                     // Last digit bypasses the shadow so the whole code lands on one edge.
                     for (int j = 0; j < NUM_DIGITS; j++)
                        committed_q[j] <= (j == NUM_DIGITS - 1) ? bcd : shadow_q[j];
                     valid_q <= 1'b1;
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                     sel_q   <= '0;
                  end else begin
                     sel_q <= sel_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   totp_scan_ctr #(
      .SCAN_DIV   (SCAN_DIV),
      .NUM_DIGITS (NUM_DIGITS)
   ) u_scan_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .index_o (scan_idx),
      .tick_o  (scan_tick)
   );

   always_comb begin
      shown_bcd_d = '0;
      for (int j = 0; j < NUM_DIGITS; j++)
         if (SEL_W'(j) == scan_idx) shown_bcd_d = committed_q[j];
   end

   // Display registers refresh one cycle after a wrap (index already advanced) or a valid change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_dly_q <= 1'b0;
         tick_q      <= 1'b0;
         scan_bcd_q  <= '0;
         digit_en_q  <= '0;
      end else begin
         valid_dly_q <= valid_q;
         tick_q      <= scan_tick;
         if (tick_q || (valid_q != valid_dly_q)) begin
            scan_bcd_q <= shown_bcd_d;
            digit_en_q <= valid_q ? NUM_DIGITS'(digit_onehot(scan_idx)) : '0;
         end
      end
   end

   assign sel      = sel_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign scan_bcd = scan_bcd_q;
   assign digit_en = digit_en_q;

endmodule

// File: tb/tb_totp_digit_scan.sv
// Scoreboard bench: stimulus pushes expected committed codes, a monitor checks
// every display update against the code that was live at that moment.
module tb_totp_digit_scan;

   typedef logic [5:0][3:0] code_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, ready, start, mode;
   logic [2:0] sel0, sel1;
   logic [3:0] bcd0, bcd1, sb0, sb1;
   logic [5:0] de0, de1;
   logic       v0, v1, b0, b1;

   assign bcd0 = mode ? 4'(9 - int'(sel0)) : 4'(int'(sel0) + 1);
   assign bcd1 = (sel1 == 3'd3) ? 4'hF : 4'(int'(sel1) + 1);

   totp_digit_scan #(.NUM_DIGITS(6), .SEL_SETTLE(1), .SCAN_DIV(4)) u0 (
      .clk(clk), .rst_n(rst_n), .ready(ready), .bcd(bcd0), .start(start),
      .sel(sel0), .scan_bcd(sb0), .digit_en(de0), .valid(v0), .busy(b0));

   totp_digit_scan #(.NUM_DIGITS(6), .SEL_SETTLE(0), .SCAN_DIV(4)) u1 (
      .clk(clk), .rst_n(rst_n), .ready(ready), .bcd(bcd1), .start(start),
      .sel(sel1), .scan_bcd(sb1), .digit_en(de1), .valid(v1), .busy(b1));

   int checks = 0;
   int errors = 0;
   code_t exp_q[$];
   localparam code_t C_INC = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
   localparam code_t C_DEC = {4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_u1(input logic [5:0] pat, output bit found);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick1();
         if (de1 == pat) found = 1'b1;
      end
   endtask

   // Monitor for u0: display updates and commits
   code_t      cur, pend;
   bit         have_cur = 0, have_pend = 0, prev_b = 0;
   logic [5:0] prev_de = '0;
   int         since = 0, prev_k = -1, run = 0, upd_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_de = '0; prev_b = 0; since = 0; prev_k = -1; run = 0;
         have_cur = 0; have_pend = 0;
      end else begin
         since++;
         if (de0 !== prev_de && de0 != 6'd0) begin
            int k;
            k = 0;
            for (int j = 0; j < 6; j++) if (de0[j]) k = j;
            chk("scan_onehot", $countones(de0), 1);
            if (have_pend) begin cur = pend; have_cur = 1; have_pend = 0; end
            if (!have_cur) begin
               checks++; errors++;
               $display("FAIL scan_no_code actual_en=%b required=blank", de0);
            end else chk("scan_digit", sb0, cur[k]);
            if (run >= 1) chk("scan_order", k, (prev_k + 1) % 6);
            if (run >= 2) chk("scan_period", since, 4);
            prev_k = k; since = 0; run++; upd_cnt++;
         end
         if (de0 == 6'd0) run = 0;
         if (prev_b && !b0 && ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL commit_unexpected actual=commit required=none");
            end else begin
               pend = exp_q.pop_front();
               have_pend = 1;
            end
         end
         prev_b = b0; prev_de = de0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      rst_n = 1'b0; ready = 1'b0; start = 1'b0; mode = 1'b0;
      repeat (3) tick1();
      chk("rst_sel", sel0, 0);  chk("rst_scan_bcd", sb0, 0); chk("rst_digit_en", de0, 0);
      chk("rst_valid", v0, 0);  chk("rst_busy", b0, 0);
      rst_n = 1'b1;
      repeat (3) tick1();
      chk("idle_valid", v0, 0); chk("idle_busy", b0, 0); chk("idle_digit_en", de0, 0);

      // ready rise: 12-cycle capture on u0, 6-cycle on u1
      exp_q.push_back(C_INC);
      ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick1();
         chk("cap_sel", sel0, c / 2);
         chk("cap_busy", b0, 1);
         chk("cap_valid", v0, 0);
         chk("u1_valid", v1, (c >= 6) ? 1 : 0);
         chk("u1_busy", b1, (c < 6) ? 1 : 0);
      end
      tick1();
      chk("commit_valid", v0, 1); chk("commit_busy", b0, 0); chk("commit_sel", sel0, 0);

      // free-running scan
      repeat (60) tick1();
      chk("scan_updates", (upd_cnt >= 7) ? 1 : 0, 1);
      wait_u1(6'b001000, found);
      chk("u1_found_d3", found, 1); chk("u1_digit3_F", sb1, 15);
      wait_u1(6'b000001, found);
      chk("u1_found_d0", found, 1); chk("u1_digit0", sb1, 1);

      // abort at capture cycle 5
      start = 1'b1; tick1(); start = 1'b0;
      chk("abort_busy_start", b0, 1);
      repeat (4) tick1();
      ready = 1'b0;
      tick1();
      chk("abort_busy", b0, 0); chk("abort_valid_kept", v0, 1);
      tick1();
      chk("abort_valid_fall", v0, 0);
      repeat (2) tick1();
      chk("abort_blank", de0, 0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick1();
         if (sb0 == 4'd6) found = 1'b1;
      end
      chk("retained_digit6", found, 1);
      exp_q.push_back(C_INC);
      ready = 1'b1;
      repeat (13) tick1();
      chk("recap_valid", v0, 1); chk("recap_busy", b0, 0);

      // recapture with new core value via start; start while busy ignored
      mode = 1'b1;
      repeat (10) tick1();
      exp_q.push_back(C_DEC);
      start = 1'b1; tick1(); start = 1'b0;
      chk("start_busy", b0, 1);
      repeat (2) tick1();
      start = 1'b1; tick1(); start = 1'b0;
      repeat (8) tick1();
      chk("busy_before_commit", b0, 1);
      tick1();
      chk("start_commit_busy", b0, 0); chk("start_commit_valid", v0, 1);
      chk("start_commit_sel", sel0, 0);
      repeat (30) tick1();

      // start with ready low does nothing
      ready = 1'b0;
      repeat (3) tick1();
      start = 1'b1; tick1(); start = 1'b0;
      chk("start_noready_busy", b0, 0);
      tick1();
      chk("start_noready_busy2", b0, 0); chk("start_noready_valid", v0, 0);
      exp_q.push_back(C_DEC);
      ready = 1'b1;
      repeat (13) tick1();
      chk("rise_valid", v0, 1);
      repeat (30) tick1();

      // async reset mid-capture and mid-scan
      start = 1'b1; tick1(); start = 1'b0;
      repeat (3) tick1();
      rst_n = 1'b0;
      #1;
      chk("arst_sel", sel0, 0);   chk("arst_scan_bcd", sb0, 0); chk("arst_digit_en", de0, 0);
      chk("arst_valid", v0, 0);   chk("arst_busy", b0, 0);
      chk("arst_u1_busy", b1, 0); chk("arst_u1_en", de1, 0);
      ready = 1'b0;
      tick1();
      rst_n = 1'b1;
      repeat (3) tick1();
      chk("post_rst_busy", b0, 0); chk("post_rst_valid", v0, 0); chk("post_rst_en", de0, 0);
      mode = 1'b0;
      exp_q.push_back(C_INC);
      ready = 1'b1;
      repeat (13) tick1();
      chk("post_rst_commit", v0, 1);
      repeat (30) tick1();

      chk("queue_drained", exp_q.size(), 0);
      chk("no_pending", have_pend, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
